// File: rtl/bch_pkg.sv
// bch_pkg: shared constants, FSM state type and the single-step LFSR helper
// used by the sequential BCH/Hamming single-error locator.
//   N_DEF/K_DEF/M_DEF : default codeword, data and syndrome widths
//   FB_DEF            : default feedback constant (syndrome of position 0)
//   M_MAX             : widest syndrome the helper function can carry
//   state_e           : locator FSM states
//   lfsr_step()       : s' = (s >> 1) ^ (s[0] ? fb : 0)
package bch_pkg;

  localparam int N_DEF = 63;
  localparam int K_DEF = 56;
  localparam int M_DEF = N_DEF - K_DEF;
  localparam logic [M_DEF-1:0] FB_DEF = 7'b1100010;

  // The helper works on a fixed wide vector; callers zero-extend their
  // M-bit state. Upper bits stay zero because the step only shifts right
  // and XORs in a zero-extended feedback constant.
  localparam int M_MAX = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic logic [M_MAX-1:0] lfsr_step(input logic [M_MAX-1:0] s,
                                                  input logic [M_MAX-1:0] fb);
    return (s >> 1) ^ (s[0] ? fb : '0);
  endfunction

endpackage

// File: rtl/bch_lfsr_advance.sv
// bch_lfsr_advance: combinational P-lane syndrome generator.
// Given the LFSR state for position idx, produces the syndromes of
// positions idx..idx+P-1 and the state for position idx+P.
//   s_i        : current LFSR state (syndrome of the first lane)
//   lane_syn_o : lane l carries the syndrome of position idx+l
//   s_adv_o    : state advanced by P steps
module bch_lfsr_advance
  import bch_pkg::*;
#(
  parameter int M = M_DEF,
  parameter logic [M-1:0] FB = FB_DEF,
  parameter int P = 1
) (
  input  logic [M-1:0]        s_i,
  output logic [P-1:0][M-1:0] lane_syn_o,
  output logic [M-1:0]        s_adv_o
);

  localparam logic [M_MAX-1:0] FB_EXT = M_MAX'(FB);

  logic [M_MAX-1:0] cur;

  always_comb begin
    lane_syn_o = '0;
    cur        = M_MAX'(s_i);
    for (int l = 0; l < P; l++) begin
      lane_syn_o[l] = cur[M-1:0];
      cur           = lfsr_step(cur, FB_EXT);
    end
    s_adv_o = cur[M-1:0];
  end

endmodule

// File: rtl/bch_err_locator_seq.sv
// bch_err_locator_seq: sequential single-error locator for shortened or
// primitive binary BCH/Hamming codes. Instead of a syndrome lookup table it
// walks an LFSR that regenerates the syndrome of each bit position and stops
// at the first position whose syndrome equals the latched input syndrome.
//
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   start, syn    : request and syndrome (sampled when start && ready)
//   ready         : high in IDLE
//   busy          : high in SEARCH or DONE
//   done          : one-cycle pulse, results valid from this cycle on
//   ep            : error pattern (one-hot or zero), held until next start
//   found         : a matching position was located
//   uncorrectable : nonzero syndrome with no match inside the search range
//   dbg_state     : current FSM state
//
// Handshake: a request is taken on a rising clk edge where start=1 and
// ready=1; start while ready=0 (SEARCH or DONE) is dropped and syn is not
// resampled. Position j maps to ep[N-1-j].
module bch_err_locator_seq
  import bch_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int K = K_DEF,
  parameter logic [N-K-1:0] FB = FB_DEF,
  parameter int P = 1,
  parameter int PARITY_FIX = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-K-1:0] syn,
  output logic           ready,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   ep,
  output logic           found,
  output logic           uncorrectable,
  output state_e         dbg_state
);

  localparam int M     = N - K;
  localparam int IW    = $clog2(N + P);
  localparam int LIMIT = (PARITY_FIX != 0) ? N : K;
  localparam logic [N-1:0] EP_LSB = N'(1);

  state_e          state_q, state_d;
  logic [M-1:0]    syn_q, syn_d;
  logic [M-1:0]    s_q, s_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [N-1:0]    ep_q, ep_d;
  logic            found_q, found_d;
  logic            unc_q, unc_d;

  logic [P-1:0][M-1:0] lane_syn;
  logic [M-1:0]        s_adv;
  logic [P-1:0]        hit;
  logic [IW-1:0]       hit_lane;
  logic [IW-1:0]       hit_pos;
  logic [IW-1:0]       ep_shamt;

  bch_lfsr_advance #(
    .M (M),
    .FB(FB),
    .P (P)
  ) u_adv (
    .s_i       (s_q),
    .lane_syn_o(lane_syn),
    .s_adv_o   (s_adv)
  );

  // Lanes past the search limit are masked so the LFSR period wrap
  // (position N aliases position 0) can never produce a false hit.
  always_comb begin
    hit      = '0;
    hit_lane = '0;
    for (int l = 0; l < P; l++) begin
      if ((int'(idx_q) + l < LIMIT) && (lane_syn[l] == syn_q)) hit[l] = 1'b1;
    end
    // Lowest matching lane wins; only one can match for a valid code.
    for (int l = P - 1; l >= 0; l--) begin
      if (hit[l]) hit_lane = IW'(l);
    end
    hit_pos  = idx_q + hit_lane;
    ep_shamt = IW'(N - 1) - hit_pos;
  end

  always_comb begin
    state_d = state_q;
    syn_d   = syn_q;
    s_d     = s_q;
    idx_d   = idx_q;
    ep_d    = ep_q;
    found_d = found_q;
    unc_d   = unc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          syn_d   = syn;
          s_d     = FB;
          idx_d   = '0;
          ep_d    = '0;
          found_d = 1'b0;
          unc_d   = 1'b0;
          state_d = (syn == '0) ? DONE : SEARCH;
        end
      end
      SEARCH: begin
        if (|hit) begin
          ep_d    = EP_LSB << ep_shamt;
          found_d = 1'b1;
          state_d = DONE;
        end else begin
          s_d   = s_adv;
          idx_d = idx_q + IW'(P);
          if (int'(idx_q) + P >= LIMIT) begin
            unc_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      syn_q   <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      ep_q    <= '0;
      found_q <= 1'b0;
      unc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      syn_q   <= syn_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      ep_q    <= ep_d;
      found_q <= found_d;
      unc_q   <= unc_d;
    end
  end

  assign ready         = (state_q == IDLE);
  assign busy          = (state_q == SEARCH) || (state_q == DONE);
  assign done          = (state_q == DONE);
  assign ep            = ep_q;
  assign found         = found_q;
  assign uncorrectable = unc_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_bch_err_locator_seq.sv
// Testbench for bch_err_locator_seq: several parameter configurations run
// side by side on shared start/syn, each checked against a table-search
// reference model of the position syndromes.
module tb_bch_err_locator_seq;

  localparam int N = 63;
  localparam int K = 56;
  localparam int M = N - K;
  localparam logic [M-1:0] FB = 7'b1100010;
  localparam int NCFG = 5;
  localparam int CFG_P  [NCFG] = '{1, 1, 3, 4, 8};
  localparam int CFG_PF [NCFG] = '{0, 1, 1, 0, 1};
  localparam int EW = 8 + 1 + 1 + N;  // {latency, found, unc, ep}
  localparam int BUDGET = 80;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [M-1:0] syn;

  always #5 clk = ~clk;

  logic           rdy [NCFG];
  logic           bsy [NCFG];
  logic           dn  [NCFG];
  logic           fnd [NCFG];
  logic           unc [NCFG];
  logic [N-1:0]   ep_w[NCFG];
  bch_pkg::state_e st_w[NCFG];

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    bch_err_locator_seq #(
      .N(N), .K(K), .FB(FB), .P(CFG_P[g]), .PARITY_FIX(CFG_PF[g])
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .syn          (syn),
      .ready        (rdy[g]),
      .busy         (bsy[g]),
      .done         (dn[g]),
      .ep           (ep_w[g]),
      .found        (fnd[g]),
      .uncorrectable(unc[g]),
      .dbg_state    (st_w[g])
    );
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [M-1:0]  syn_tbl[N];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Syndrome of every position, built straight from the LFSR rule.
  task automatic build_table();
    logic [M-1:0] s;
    s = FB;
    for (int j = 0; j < N; j++) begin
      syn_tbl[j] = s;
      s = (s >> 1) ^ (s[0] ? FB : '0);
    end
  endtask

  function automatic logic [EW-1:0] model(input logic [M-1:0] s, input int p,
                                          input int pf);
    int lim;
    int j;
    logic [N-1:0] one;
    logic [7:0] lat;
    lim = (pf != 0) ? N : K;
    j = -1;
    one = 1;
    for (int k = 0; k < lim; k++) begin
      if (j < 0 && syn_tbl[k] == s) j = k;
    end
    if (s == '0) return {8'd1, 1'b0, 1'b0, {N{1'b0}}};
    if (j >= 0) begin
      lat = 8'(2 + j / p);
      return {lat, 1'b1, 1'b0, one << (N - 1 - j)};
    end
    lat = 8'(2 + (lim - 1) / p);
    return {lat, 1'b0, 1'b1, {N{1'b0}}};
  endfunction

  // ---------------- driver ----------------
  // Issues one request; optionally pulses an extra start at t+5 which
  // must be ignored by every (still busy) instance.
  task automatic run_txn(input logic [M-1:0] s, input bit inject);
    int lat_got[NCFG];
    int ndone[NCFG];
    logic [N-1:0] ep_got[NCFG];
    logic fnd_got[NCFG];
    logic unc_got[NCFG];
    logic [EW-1:0] e[NCFG];
    int cycle;
    bit all_seen;
    for (int g = 0; g < NCFG; g++) begin
      exp_q.push_back(model(s, CFG_P[g], CFG_PF[g]));
      lat_got[g] = 0; ndone[g] = 0; ep_got[g] = '0; fnd_got[g] = 0; unc_got[g] = 0;
    end
    @(negedge clk);
    syn = s;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    syn = M'($urandom);  // must not be resampled
    cycle = 1;
    for (int g = 0; g < NCFG; g++) check($sformatf("ready_low_c%0d", g), rdy[g], 1'b0);
    forever begin
      all_seen = 1;
      for (int g = 0; g < NCFG; g++) begin
        if (dn[g]) begin
          ndone[g]++;
          if (lat_got[g] == 0) begin
            lat_got[g] = cycle; ep_got[g] = ep_w[g]; fnd_got[g] = fnd[g]; unc_got[g] = unc[g];
          end
        end
        if (lat_got[g] == 0) all_seen = 0;
      end
      if (all_seen || cycle >= BUDGET) break;
      if (inject && cycle == 5) begin start = 1'b1; syn = 7'b1111010; end
      if (inject && cycle == 6) start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      cycle++;
    end
    start = 1'b0;
    for (int g = 0; g < NCFG; g++) begin
      e[g] = exp_q.pop_front();
      check($sformatf("lat_c%0d_s%0h", g, s), lat_got[g], e[g][EW-1 -: 8]);
      check($sformatf("found_c%0d_s%0h", g, s), fnd_got[g], e[g][N+1]);
      check($sformatf("unc_c%0d_s%0h", g, s), unc_got[g], e[g][N]);
      check($sformatf("ep_c%0d_s%0h", g, s), ep_got[g], e[g][N-1:0]);
      check($sformatf("pulse_c%0d_s%0h", g, s), ndone[g], 1);
    end
    @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("idle_rdy_c%0d", g), {rdy[g], dn[g]}, 2'b10);
      check($sformatf("hold_ep_c%0d", g), ep_w[g], e[g][N-1:0]);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int g = 0; g < NCFG; g++) begin
      check($sformatf("%s_c%0d", tag, g),
            {rdy[g], bsy[g], dn[g], fnd[g], unc[g], ep_w[g]},
            {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, {N{1'b0}}});
      check($sformatf("%s_st_c%0d", tag, g), st_w[g], bch_pkg::IDLE);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [M-1:0] order[127];
    logic [M-1:0] tmp;
    int r;
    rst_n = 1'b0;
    start = 1'b0;
    syn = '0;
    build_table();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // directed cases
    run_txn(7'b1100010, 0);
    run_txn(7'b1000101, 0);
    run_txn(7'b0110001, 0);
    run_txn(7'b1000000, 0);
    run_txn(7'b0000000, 0);
    run_txn(7'b1000101, 1);

    // reset during a search
    @(negedge clk);
    syn = 7'b1000101;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_state("async_rst");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int g = 0; g < NCFG; g++) check($sformatf("rst_nodone_c%0d", g), dn[g], 1'b0);
    end
    rst_n = 1'b1;
    run_txn(7'b0110001, 0);

    // all nonzero syndromes in shuffled order
    for (int i = 0; i < 127; i++) order[i] = M'(i + 1);
    for (int i = 126; i > 0; i--) begin
      r = $urandom_range(0, i);
      tmp = order[i]; order[i] = order[r]; order[r] = tmp;
    end
    for (int i = 0; i < 127; i++) run_txn(order[i], 0);

    // random extras, zero included
    for (int i = 0; i < 20; i++) run_txn(M'($urandom_range(0, 127)), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bch_err_locator_seq.md
Name: bch_err_locator_seq

Overview:
Parametrised sequential single-error locator for shortened/primitive binary BCH/Hamming codes. It replaces a hard-coded syndrome→error-pattern case table with an LFSR search that regenerates each position's syndrome on the fly. It adds a start/done handshake, selectable parity-bit correction, P positions per cycle, and an uncorrectable flag. It sits between the syndrome calculator and the codeword XOR-correction stage.

Parameters:
N, 63, codeword length (bits)
K, 56, data length; M = N-K syndrome width (derived, 7 at defaults)
FB, 7'b1100010, M-bit LFSR feedback constant, equal to the syndrome of position 0 (ep[N-1])
P, 1, positions tested per cycle (1..8, need not divide N)
PARITY_FIX, 0, 0: search data positions 0..K-1 only; 1: search all 0..N-1

Ports:
clk  in  1  clock
rst_n  in  1  reset: asynchronous, active-low
start  in  1  request; accepted only when ready=1
syn  in  M  syndrome, sampled on accepted start
ready  out  1  high in IDLE
busy  out  1  high in SEARCH or DONE
done  out  1  one-cycle pulse; result valid from this cycle on
ep  out  N  error pattern (one-hot or zero), held until next accepted start
found  out  1  a match was located
uncorrectable  out  1  nonzero syndrome, no match within searched range

Behaviour:
- Reset: state=IDLE, ready=1, busy=0, done=0, ep=0, found=0, uncorrectable=0. Reset mid-search aborts and clears the same way; no done pulse is issued.
- Position numbering: pos 0 ↔ ep[N-1], pos j ↔ ep[N-1-j]. LIMIT = PARITY_FIX ? N : K.
- LFSR step: s' = (s >> 1) ^ (s[0] ? FB : 0). s_0 = FB, and s_j is the syndrome of pos j. At defaults, s_55 = 1000101 and s_56..s_62 = 1000000, 0100000, …, 0000001.
- FSM IDLE→SEARCH→DONE→IDLE.
  - IDLE, start=1 (cycle t): latch syn, load s=FB, idx=0, clear ep/found/uncorrectable.
  - If syn==0: go to DONE directly. done is asserted at t+1 with ep=0, found=0, uncorrectable=0.
  - SEARCH: each cycle, compare s_idx..s_idx+P-1 against the latched syn. Lanes with position ≥ LIMIT are masked.
  - On the first match at lane L: ep[N-1-(idx+L)]<=1, found<=1, go to DONE. For any syndrome, at most one lane matches.
  - No match: s advances P steps and idx+=P. If idx+P ≥ LIMIT after this group, uncorrectable<=1 and go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency:
  - Match at pos j: done at t+2+floor(j/P).
  - No match: done at t+2+floor((LIMIT-1)/P).
- start while busy is ignored, and syn is not resampled.
- start in the same cycle as a done pulse is ignored (ready=0 in DONE).
- idx width is ceil(log2(N+P)). No wrap-around: the search always terminates at LIMIT.

Decomposition:
- Package bch_pkg holds:
  - default N/K/M/FB constants;
  - state enum {IDLE, SEARCH, DONE};
  - function lfsr_step(s, fb).
- One sub-module, bch_lfsr_advance: combinational, parameters M/FB/P. It outputs the P lane syndromes and the P-step-advanced state. The top holds the FSM, idx, and result registers.

Test Plan:
- Defaults, P=1: syn=1100010 at t → done at t+2, ep[62]=1 only, found=1, uncorrectable=0.
- Defaults, P=1: syn=1000101 → done at t+57, ep[7]=1, found=1. syn=0110001 → ep[61], done t+3.
- syn=1000000: with PARITY_FIX=0 → done t+57, ep=0, uncorrectable=1. With PARITY_FIX=1 → ep[6], done t+58.
- syn=0 → done at t+1, ep=0, found=0, uncorrectable=0. ready returns high at t+2.
- P=4, syn=1000101 → done at t+15, ep[7]. Sweep all 127 nonzero syndromes against a golden lfsr_step model for P∈{1,3,4,8}.
- Pulse start with syn=1111010 at t+5 during a search → ignored, result unchanged. Drop rst_n at t+10 → all outputs 0 asynchronously, no done; a new start afterwards behaves normally.
